serial_level_decoder: RTL and testbench

SERIAL_LEVEL_DECODER -- requirements
Module: serial_level_decoder

---
 rtl/serial_level_decoder.sv | 136 +++++++++++++
 tb/tb_serial_level_decoder.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/serial_level_decoder.sv
// Serial thermometer-code frame decoder: recovers the upstream level from
// one 8-slot frame per sof, flags malformed/misaligned frames, tracks lock.
module serial_level_decoder #(
  parameter int FRAME_LEN = 8
) (
  input  logic       clk,
  input  logic       clear_n,
  input  logic       enable,
  input  logic       sof,
  input  logic       in_bit,
  output logic [2:0] level,
  output logic       level_valid,
  output logic       frame_err,
  output logic       locked,
  output logic [7:0] err_count
);

  localparam logic [2:0] LAST_SLOT = 3'(FRAME_LEN - 1);

  typedef enum logic {HUNT, RUN} state_t;

  state_t     r_state;
  logic [2:0] r_slot;
  logic [3:0] r_ones;
  logic       r_seen_zero;
  logic       r_bad;
  logic [2:0] r_level;
  logic       r_level_valid;
  logic       r_frame_err;
  logic       r_locked;
  logic [7:0] r_err_count;

  logic [3:0] w_ones_next;
  logic       w_bad_next;
  logic [2:0] w_level_next;
  logic [7:0] w_err_next;

  // Frame bookkeeping including the bit being sampled this cycle.
  always_comb begin
    w_ones_next  = r_ones + 4'(in_bit);
    w_bad_next   = r_bad | (r_seen_zero & in_bit);
    w_level_next = 3'(w_ones_next - 4'd1);
    w_err_next   = (r_err_count == '1) ? r_err_count : r_err_count + 8'd1;
  end

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      r_state       <= HUNT;
      r_slot        <= '0;
      r_ones        <= '0;
      r_seen_zero   <= 1'b0;
      r_bad         <= 1'b0;
      r_level       <= '0;
      r_level_valid <= 1'b0;
      r_frame_err   <= 1'b0;
      r_locked      <= 1'b0;
      r_err_count   <= '0;
    end else begin
      r_level_valid <= 1'b0;
      r_frame_err   <= 1'b0;
      if (!enable) begin
        r_state     <= HUNT;
        r_slot      <= '0;
        r_ones      <= '0;
        r_seen_zero <= 1'b0;
        r_bad       <= 1'b0;
        r_locked    <= 1'b0;
      end else begin
        case (r_state)
          HUNT: begin
            if (sof) begin
              r_state     <= RUN;
              r_slot      <= 3'd1;
              r_ones      <= 4'(in_bit);
              r_seen_zero <= ~in_bit;
              r_bad       <= ~in_bit;
            end
          end
          RUN: begin
            if (r_slot == LAST_SLOT) begin
              // Completion wins; a coincident sof only restarts the next frame.
              if (w_bad_next) begin
                r_frame_err <= 1'b1;
                r_locked    <= 1'b0;
                r_err_count <= w_err_next;
              end else begin
                r_level_valid <= 1'b1;
                r_level       <= w_level_next;
                r_locked      <= 1'b1;
              end
              if (sof) begin
                r_slot      <= 3'd1;
                r_ones      <= 4'(in_bit);
                r_seen_zero <= ~in_bit;
                r_bad       <= ~in_bit;
              end else begin
                r_slot      <= '0;
                r_ones      <= '0;
                r_seen_zero <= 1'b0;
                r_bad       <= 1'b0;
              end
            end else if (sof) begin
              if (r_slot != '0) begin
                r_frame_err <= 1'b1;
                r_locked    <= 1'b0;
                r_err_count <= w_err_next;
              end
              r_slot      <= 3'd1;
              r_ones      <= 4'(in_bit);
              r_seen_zero <= ~in_bit;
              r_bad       <= ~in_bit;
            end else if (r_slot == '0) begin
              r_frame_err <= 1'b1;
              r_locked    <= 1'b0;
              r_err_count <= w_err_next;
              r_state     <= HUNT;
            end else begin
              r_slot      <= r_slot + 3'd1;
              r_ones      <= w_ones_next;
              r_seen_zero <= r_seen_zero | ~in_bit;
              r_bad       <= w_bad_next;
            end
          end
          default: r_state <= HUNT;
        endcase
      end
    end
  end

  assign level       = r_level;
  assign level_valid = r_level_valid;
  assign frame_err   = r_frame_err;
  assign locked      = r_locked;
  assign err_count   = r_err_count;

endmodule

// File: tb/tb_serial_level_decoder.sv
// Directed scoreboard bench for serial_level_decoder: expected pulses are
// queued as frames are driven and checked when the decoder emits them.
module tb_serial_level_decoder;

  logic       clk = 1'b0;
  logic       clear_n = 1'b0;
  logic       enable = 1'b0;
  logic       sof = 1'b0;
  logic       in_bit = 1'b0;
  logic [2:0] level;
  logic       level_valid;
  logic       frame_err;
  logic       locked;
  logic [7:0] err_count;

  serial_level_decoder #(.FRAME_LEN(8)) dut (
    .clk(clk), .clear_n(clear_n), .enable(enable), .sof(sof), .in_bit(in_bit),
    .level(level), .level_valid(level_valid), .frame_err(frame_err),
    .locked(locked), .err_count(err_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         is_err;
    logic [2:0] lvl;
    logic [7:0] ec;
  } exp_t;

  exp_t       q[$];
  int         n_checks = 0;
  int         n_fail = 0;
  logic [2:0] m_level = '0;
  logic [7:0] m_err = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input bit is_err, input logic [2:0] lvl);
    exp_t e;
    if (is_err) m_err = (m_err == 8'd255) ? 8'd255 : m_err + 8'd1;
    else        m_level = lvl;
    e.is_err = is_err;
    e.lvl    = m_level;
    e.ec     = m_err;
    q.push_back(e);
  endtask

  task automatic check_outputs();
    exp_t e;
    chk("pulse_exclusive", 32'(level_valid & frame_err), 32'd0);
    if (level_valid | frame_err) begin
      if (q.size() == 0) begin
        chk("unexpected_pulse", {30'd0, level_valid, frame_err}, 32'd0);
      end else begin
        e = q.pop_front();
        chk("pulse_kind_err", 32'(frame_err), 32'(e.is_err));
        chk("pulse_level", 32'(level), 32'(e.lvl));
        chk("pulse_locked", 32'(locked), 32'(!e.is_err));
        chk("pulse_err_count", 32'(err_count), 32'(e.ec));
      end
    end
  endtask

  task automatic drive(input logic s, input logic b);
    sof    = s;
    in_bit = b;
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  // Bench-side decode: slot 0 must be 1 and no 1 may follow a 0.
  task automatic send_bits(input logic [7:0] p);
    bit ok = p[0];
    bit seen0 = 1'b0;
    int ones = 0;
    for (int i = 0; i < 8; i++) begin
      if (p[i]) begin
        ones++;
        if (seen0) ok = 1'b0;
      end else begin
        seen0 = 1'b1;
      end
    end
    if (ok) push(1'b0, 3'(ones - 1));
    else    push(1'b1, 3'd0);
    for (int i = 0; i < 8; i++) drive(i == 0, p[i]);
  endtask

  task automatic send_frame(input int addr);
    logic [7:0] p;
    for (int i = 0; i < 8; i++) p[i] = (i <= addr);
    send_bits(p);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_level"}, 32'(level), 32'd0);
    chk({tag, "_level_valid"}, 32'(level_valid), 32'd0);
    chk({tag, "_frame_err"}, 32'(frame_err), 32'd0);
    chk({tag, "_locked"}, 32'(locked), 32'd0);
    chk({tag, "_err_count"}, 32'(err_count), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    #2;
    check_all_zero("reset");
    #10;
    clear_n = 1'b1;
    enable  = 1'b1;
    drive(1'b0, 1'b1);
    drive(1'b0, 1'b0);

    // Single frame, addr 3.
    send_frame(3);
    chk("addr3_level", 32'(level), 32'd3);
    chk("addr3_locked", 32'(locked), 32'd1);
    chk("addr3_drained", 32'(q.size()), 32'd0);

    // Contiguous sweep of every level.
    for (int a = 0; a < 8; a++)
      for (int k = 0; k < 8; k++) send_frame(a);
    chk("sweep_err_count", 32'(err_count), 32'd0);
    chk("sweep_level", 32'(level), 32'd7);
    chk("sweep_drained", 32'(q.size()), 32'd0);

    // Malformed frames.
    send_bits(8'b0000_0000);
    send_bits(8'b0000_0101);
    chk("bad_err_count", 32'(err_count), 32'd2);
    chk("bad_locked", 32'(locked), 32'd0);
    chk("bad_level_held", 32'(level), 32'd7);
    chk("bad_drained", 32'(q.size()), 32'd0);

    // Early sof at slot 4.
    send_frame(2);
    drive(1'b1, 1'b1);
    for (int i = 1; i < 4; i++) drive(1'b0, 1'b1);
    push(1'b1, 3'd0);
    send_frame(5);
    chk("early_level", 32'(level), 32'd5);
    chk("early_locked", 32'(locked), 32'd1);
    chk("early_err_count", 32'(err_count), 32'd3);
    chk("early_drained", 32'(q.size()), 32'd0);

    // Missing sof after slot 7, then relock.
    send_frame(4);
    push(1'b1, 3'd0);
    drive(1'b0, 1'b1);
    chk("missing_locked", 32'(locked), 32'd0);
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b1);
    chk("missing_drained", 32'(q.size()), 32'd0);
    send_frame(6);
    chk("relock_locked", 32'(locked), 32'd1);
    chk("relock_level", 32'(level), 32'd6);

    // Enable drop mid-frame.
    drive(1'b1, 1'b1);
    drive(1'b0, 1'b1);
    enable = 1'b0;
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b1);
    chk("disable_locked", 32'(locked), 32'd0);
    chk("disable_level_held", 32'(level), 32'd6);
    chk("disable_err_held", 32'(err_count), 32'(m_err));
    chk("disable_drained", 32'(q.size()), 32'd0);
    enable = 1'b1;
    send_frame(1);
    chk("reenable_level", 32'(level), 32'd1);

    // Saturation.
    repeat (300) send_bits(8'b0000_0000);
    chk("sat_err_count", 32'(err_count), 32'd255);
    chk("sat_level_held", 32'(level), 32'd1);
    chk("sat_drained", 32'(q.size()), 32'd0);

    // Asynchronous clear mid-frame.
    drive(1'b1, 1'b1);
    drive(1'b0, 1'b1);
    drive(1'b0, 1'b1);
    #2;
    clear_n = 1'b0;
    #1;
    check_all_zero("async_clear");
    m_level = '0;
    m_err   = '0;
    #2;
    clear_n = 1'b1;
    drive(1'b0, 1'b1);
    drive(1'b0, 1'b1);
    send_frame(5);
    chk("post_clear_level", 32'(level), 32'd5);
    chk("post_clear_locked", 32'(locked), 32'd1);
    chk("post_clear_err_count", 32'(err_count), 32'd0);
    chk("final_drained", 32'(q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
